pipo_share_arbiter: RTL
=======================

# pipo_share_arbiter

- Shares one n-bit parallel-in/parallel-out data register among R requesters.
- Selects one requester with round-robin priority and grants it with a one-cycle handshake.
- Loads the granted requester's word into the register, then holds it stable for a programmable number of cycles before granting again.
- Sits between several producer blocks and the single shared register that downstream logic reads.

## Interface
- n, 5: data width of each requester word and of Q.
- R, 4: number of requesters (2..8).
- HOLD, 2: idle cycles after a load before the next grant; 0 is legal.
- clk  in  1: sole clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- req  in  R: bit i is high while requester i wants to write.
- data_in  in  R*n: requester i's word on bits [i*n +: n].
- gnt  out  R: one-hot grant, high for exactly one cycle.
- Q  out  n: shared register contents.
- owner  out  max(1,clog2(R)): index of the requester that last loaded Q.
- valid  out  1: Q holds a loaded word since reset.
- busy  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If req is nonzero, pick a winner by searching from index ptr upward, wrapping modulo R.
  - Register gnt as the winner's one-hot value and go to LOAD.
  - If req is zero, stay in IDLE with gnt=0.
- LOAD, gnt high for this cycle only:
  - If req[winner] is still high: Q <= winner's data slice, owner <= winner, valid <= 1, ptr <= (winner+1) mod R.
  - Then go to HOLD with counter = HOLD, or directly to IDLE if HOLD==0.
  - If req[winner] has dropped: abort. No load; Q, owner, valid and ptr are unchanged; go to IDLE.
- HOLD: decrement the counter each cycle; when it reaches 1, the next state is IDLE. Requests are ignored in this state.
- Requesters keep data_in stable and req high through their gnt cycle, and deassert req the cycle after gnt unless they want another turn.
- Winner search rules:
  - A requester that keeps req asserted is re-served only after every other active requester has had a turn.
  - ptr wraps from R-1 to 0.
- Changes on unselected req bits during LOAD or HOLD have no effect.
- Reset, in any state, mid-operation included: state=IDLE, gnt=0, Q=0, owner=0, valid=0, busy=0, ptr=0, counter=0.
  - Reset wins over a same-cycle load.

## Timing
- req first sampled high at edge k -> gnt high in cycle k+1 -> Q, owner and valid updated at edge k+2.
- busy is high from cycle k+1 through the last HOLD cycle.
- Minimum spacing between grants is 2+HOLD cycles; with HOLD=2, at most one load per 4 cycles.
- All outputs are registered; there are no combinational paths from req or data_in to any output.
- Arithmetic:
  - ptr and owner are clog2(R) bits.
  - The wrap is an explicit compare against R-1, so non-power-of-2 R is handled.
  - The HOLD counter is clog2(HOLD+1) bits wide, minimum 1.

## Structure
- Package pipo_arb_pkg holds:
  - State encodings IDLE=2'd0, LOAD=2'd1, HOLD=2'd2.
  - Default parameter constants.
  - A width helper for ptr and counter.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs one-hot winner and binary index.
- The FSM, counter, ptr and the enabled data register live in the top module.
- The data register is written inline with a load enable.

## Test plan
All scenarios use n=5, R=4, HOLD=2.
- Reset: assert reset for 2 cycles with random req -> Q=5'b00000, gnt=0, valid=0, busy=0, owner=0.
- Single requester: req=4'b0100, data slice 2 = 5'b10101 -> gnt=4'b0100 for one cycle; Q=5'b10101, owner=2, valid=1 two cycles after req is sampled; busy high for 3 cycles.
- Round-robin under contention:
  - Stimulus: req=4'b1111 held; slices 0..3 = 5'b00001, 5'b00010, 5'b00100, 5'b01000.
  - Required: grants in order 0,1,2,3,0; Q follows the same sequence; grants spaced exactly 4 cycles apart.
- Wrap and skip: ptr=3 after serving index 2, then req=4'b0011 -> next grant goes to 0, then 1; index 3 is never granted.
- Abort: the winner drops req during its gnt cycle -> Q and valid unchanged; FSM returns to IDLE; the same index wins again when it re-requests.
- Reset mid-HOLD: assert reset one cycle after a load of 5'b11010 -> Q=0, valid=0 on the next cycle; the first post-reset grant with req=4'b1111 goes to index 0.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// -----------------------------------------------------------------------------
// pipo_arb_pkg
// Shared definitions for the shared PIPO-register arbiter:
//   - FSM state encoding (IDLE/LOAD/HOLD)
//   - default parameter values (word width, requester count, hold length)
//   - width helper used for the round-robin pointer and the hold counter
// -----------------------------------------------------------------------------
package pipo_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int DEF_N    = 5;
  localparam int DEF_R    = 4;
  localparam int DEF_HOLD = 2;

  // Bits needed to encode values 0..v-1, never less than one bit so that
  // degenerate sizes (v == 1) still produce a legal vector.
  function automatic int width_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pipo_share_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. Starting at index ptr and walking
// upward (wrapping R-1 -> 0), the first asserted request bit wins.
// Ports:
//   req    in  [R-1:0]   request vector
//   ptr    in  [PW-1:0]  highest-priority index for this search
//   winner out [R-1:0]   one-hot winner, all-zero when req is zero
//   idx    out [PW-1:0]  binary index of the winner, zero when req is zero
// -----------------------------------------------------------------------------
module rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int R  = DEF_R,
  parameter int PW = width_min1(R)
) (
  input  logic [R-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [R-1:0]  winner,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [PW-1:0] cand;
    // NOTE: every output and temporary gets a value before any branch so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = ptr;
    for (int i = 0; i < R; i++) begin
      if (!found && req[cand]) begin
        found       = 1'b1;
        winner[cand] = 1'b1;
        idx         = cand;
      end
      // Explicit compare against R-1 keeps the wrap correct for R that is not
      // a power of two.
      cand = (cand == PW'(R - 1)) ? '0 : cand + PW'(1);
    end
  end

endmodule

// File: rtl/pipo_share_arbiter.sv
// -----------------------------------------------------------------------------
// pipo_share_arbiter
// One N-bit parallel-in/parallel-out register shared by R producers. A
// round-robin arbiter grants one requester per turn with a single-cycle gnt
// pulse, loads that requester's word into Q during the gnt cycle, then holds
// the register stable for HOLD cycles before arbitrating again.
// Ports:
//   clk      in   1        rising-edge clock
//   reset    in   1        synchronous, active-high reset
//   req      in   [R-1:0]  request bit per producer
//   data_in  in   [R*N-1:0] producer i's word on bits [i*N +: N]
//   gnt      out  [R-1:0]  one-hot grant, high for exactly one cycle
//   Q        out  [N-1:0]  shared register contents
//   owner    out  [PW-1:0] index of the producer that last loaded Q
//   valid    out  1        Q holds a loaded word since reset
//   busy     out  1        FSM is in LOAD or HOLD
// All outputs are registered.
// -----------------------------------------------------------------------------
module pipo_share_arbiter
  import pipo_arb_pkg::*;
#(
  parameter  int N    = DEF_N,
  parameter  int R    = DEF_R,
  parameter  int HOLD = DEF_HOLD,
  localparam int PW   = width_min1(R),
  localparam int CW   = width_min1(HOLD + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] data_in,
  output logic [R-1:0]   gnt,
  output logic [N-1:0]   Q,
  output logic [PW-1:0]  owner,
  output logic           valid,
  output logic           busy
);

  state_t        state;
  logic [PW-1:0] ptr;      // search start for the next arbitration
  logic [PW-1:0] win_idx;  // requester granted in the current LOAD cycle
  logic [CW-1:0] cnt;      // remaining HOLD cycles
  logic [R-1:0]  pick_oh;
  logic [PW-1:0] pick_idx;
  logic          load_en;

  rr_pick #(
    .R  (R),
    .PW (PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_oh),
    .idx    (pick_idx)
  );

  // The load only happens if the winner is still requesting in its gnt cycle;
  // a dropped request aborts the turn without touching Q or the pointer.
  assign load_en = (state == S_LOAD) && req[win_idx];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state   <= S_IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      ptr     <= '0;
      win_idx <= '0;
      cnt     <= '0;
    end else begin
      gnt <= '0;  // grant is a single-cycle pulse by default
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt     <= pick_oh;
            win_idx <= pick_idx;
            state   <= S_LOAD;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        S_LOAD: begin
          if (load_en) begin
            // Advance past the winner so a persistent requester waits for
            // every other active requester before being served again.
            ptr <= (win_idx == PW'(R - 1)) ? '0 : win_idx + PW'(1);
            if (HOLD == 0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_HOLD;
              cnt   <= CW'(HOLD);
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_HOLD: begin
          // Requests are ignored here; the register is simply held.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shared data register with load enable. Reset takes priority, so a reset
  // in the same cycle as a load leaves the register cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q     <= '0;
      owner <= '0;
      valid <= 1'b0;
    end else if (load_en) begin
      Q     <= data_in[win_idx*N +: N];
      owner <= win_idx;
      valid <= 1'b1;
    end
  end

endmodule
